jt51_host_wr: RTL and testbench
===============================

Name: jt51_host_wr

Overview:
- Bus-side initiator that drives the jt51 CPU write interface (cs_n, wr_n, a0, d_in) and reads its status byte (d_out).
- Accepts (register address, data) commands on a valid/ready port and buffers them in a small FIFO.
- Performs each YM2151 register write as an address phase (a0=0) followed by a data phase (a0=1), polling the busy bit before each phase.
- Sits between a sequencer/CPU-less player (e.g. VGM playback) and the jt51 instance.

Parameters:
- FIFO_AW, 2: FIFO depth is 2**FIFO_AW entries.
- SETTLE, 2: clk cycles to wait after a write strobe before busy is sampled (jt51 raises busy one clk after capture); must be ≥1.
- TIMEOUT, 1023: maximum poll cycles with busy=1 before the write is forced.
- SKIP_SAME_ADDR, 0: if 1, the address phase is skipped when cmd_addr equals the last address written.

Ports:
- clk  in  1  system clock; the same clk that feeds the jt51 instance.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO not full.
- cmd_addr  in  8  YM2151 register address.
- cmd_data  in  8  register data.
- ym_cs_n  out  1  to jt51 cs_n.
- ym_wr_n  out  1  to jt51 wr_n.
- ym_a0  out  1  to jt51 a0.
- ym_din  out  8  to jt51 d_in.
- ym_dout  in  8  from jt51 d_out; bit 7 is busy.
- idle  out  1  FSM in IDLE and FIFO empty.
- fifo_level  out  FIFO_AW+1  current number of FIFO entries.
- timeout_err  out  1  sticky; set when a poll times out.
- err_clr  in  1  clears timeout_err.

Behaviour:
- Reset (async, rst_n=0):
  - ym_cs_n=1, ym_wr_n=1, ym_a0=0, ym_din=0.
  - FIFO emptied, fifo_level=0, cmd_ready=1.
  - FSM=IDLE, timeout_err=0, last-address-valid=0.
  - A reset mid-write abandons the command with no further strobe.
- FIFO:
  - Push on cmd_valid&cmd_ready; pop by the FSM in IDLE.
  - Push and pop in the same cycle keep the level unchanged.
  - cmd_ready=0 when level=2**FIFO_AW.
  - Pointers wrap modulo depth.
- All ym_* outputs are registered. Strobes are asserted for exactly one clk, because a longer strobe could be recaptured after busy clears.
- FSM states: IDLE, POLL_A, WR_A, SET_A, POLL_D, WR_D, SET_D.
  - IDLE: if FIFO not empty, pop into cur_addr/cur_data.
    - If SKIP_SAME_ADDR=1, last-address-valid is set and cur_addr equals last_addr, go to POLL_D.
    - Otherwise go to POLL_A.
  - POLL_A/POLL_D: a poll counter starts at 0.
    - If ym_dout[7]=0, go to WR_A/WR_D.
    - Otherwise the counter increments; when it reaches TIMEOUT, set timeout_err and go to WR_x anyway.
  - WR_A: outputs cs_n=0, wr_n=0, a0=0, din=cur_addr for this cycle only. Record last_addr and set valid. Go to SET_A.
  - WR_D: same strobe with a0=1 and din=cur_data. Go to SET_D.
  - SET_A/SET_D: strobes inactive; stay for SETTLE cycles, then go to POLL_D / IDLE respectively.
- Outside WR states: cs_n=1, wr_n=1; a0 and din hold their last value.
- Latency with busy=0, SETTLE=2, command accepted at edge 0 into an empty FIFO:
  - POLL_A at edge 1.
  - Address strobe during cycle 2.
  - Data strobe during cycle 6.
  - idle=1 after edge 9.
  - A back-to-back queued command starts POLL_A at edge 10.
- err_clr:
  - err_clr clears timeout_err.
  - If err_clr and a new timeout occur in the same cycle, set wins.
- last_addr tracking:
  - last_addr tracks only writes issued by this block.
  - Any reset clears its valid bit, forcing the next address phase.

Test Plan:
- Single write, busy tied 0: addr=0x08, data=0x7F → address strobe (a0=0, din=0x08) in cycle 2 and data strobe (a0=1, din=0x7F) in cycle 6, each exactly 1 clk low; idle=1 after edge 9.
- busy held 1 for 20 cycles after the address strobe → data strobe appears 1 cycle after busy falls; no strobe while busy=1; timeout_err=0.
- busy stuck at 1, TIMEOUT=15 → write forced after 15 poll cycles; timeout_err=1 until err_clr pulse, then 0.
- Push 5 commands with FIFO_AW=2 and busy=1 → cmd_ready=0 at level 4; 5th accepted after the first pop; all 5 writes issued in order.
- SKIP_SAME_ADDR=1, commands (0x20,0x01),(0x20,0x02),(0x28,0x03) → address strobes only for 0x20 (first) and 0x28; three data strobes with 0x01, 0x02, 0x03.
- rst_n low during SET_A → cs_n/wr_n=1 immediately, fifo_level=0; after release no data strobe is issued and idle=1.

Source files
------------

// File: rtl/jt51_host_wr.sv
// rtl/jt51_host_wr.sv - queued host-side register writer for the jt51 CPU port
module jt51_host_wr #(
   parameter int FIFO_AW        = 2,
   parameter int SETTLE         = 2,
   parameter int TIMEOUT        = 1023,
   parameter int SKIP_SAME_ADDR = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [7:0]         cmd_addr,
   input  logic [7:0]         cmd_data,
   output logic               ym_cs_n,
   output logic               ym_wr_n,
   output logic               ym_a0,
   output logic [7:0]         ym_din,
   input  logic [7:0]         ym_dout,
   output logic               idle,
   output logic [FIFO_AW:0]   fifo_level,
   output logic               timeout_err,
   input  logic               err_clr
);

   localparam int DEPTH = 1 << FIFO_AW;
   // Poll counter only needs to reach TIMEOUT-1, settle counter SETTLE-1.
   localparam int PW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam int SW = (SETTLE < 2) ? 1 : $clog2(SETTLE);

   typedef enum logic [2:0] {
      IDLE, POLL_A, WR_A, SET_A, POLL_D, WR_D, SET_D
   } state_t;

   logic [15:0]        mem_q [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [FIFO_AW:0]   level_q, level_d;
   logic [15:0]        head;
   logic               push, pop;

   state_t             state_q, state_d;
   logic [7:0]         cur_addr_q, cur_addr_d;
   logic [7:0]         cur_data_q, cur_data_d;
   logic [PW-1:0]      poll_cnt_q, poll_cnt_d;
   logic [SW-1:0]      set_cnt_q, set_cnt_d;
   logic [7:0]         last_addr_q, last_addr_d;
   logic               last_valid_q, last_valid_d;
   logic               err_q, err_d;
   logic               cs_n_q, cs_n_d;
   logic               wr_n_q, wr_n_d;
   logic               a0_q, a0_d;
   logic [7:0]         din_q, din_d;
   logic               busy;
   logic               unused_dout;

   assign busy        = ym_dout[7];
   assign unused_dout = ^ym_dout[6:0];

   assign cmd_ready = (level_q != (FIFO_AW+1)'(DEPTH));
   assign push      = cmd_valid & cmd_ready;
   assign pop       = (state_q == IDLE) && (level_q != '0);
   assign head      = mem_q[rd_ptr_q];

   // FIFO storage: data only, no reset needed since level gates every read
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {cmd_addr, cmd_data};
   end

   // FIFO pointers and occupancy
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
      if (push && !pop)      level_d = level_q + (FIFO_AW+1)'(1);
      else if (!push && pop) level_d = level_q - (FIFO_AW+1)'(1);
   end

   // Write sequencer next state; bus outputs follow the next state so they are registered
   always_comb begin
      state_d      = state_q;
      cur_addr_d   = cur_addr_q;
      cur_data_d   = cur_data_q;
      poll_cnt_d   = poll_cnt_q;
      set_cnt_d    = set_cnt_q;
      last_addr_d  = last_addr_q;
      last_valid_d = last_valid_q;
      err_d        = err_q & ~err_clr;

      case (state_q)
         IDLE: begin
            if (level_q != '0) begin
               cur_addr_d = head[15:8];
               cur_data_d = head[7:0];
               poll_cnt_d = '0;
               if ((SKIP_SAME_ADDR != 0) && last_valid_q && (head[15:8] == last_addr_q))
                  state_d = POLL_D;
               else
                  state_d = POLL_A;
            end
         end
         POLL_A, POLL_D: begin
            if (!busy) begin
               state_d = (state_q == POLL_A) ? WR_A : WR_D;
            end else if (poll_cnt_q == PW'(TIMEOUT - 1)) begin
               // Chip never released busy: force the write rather than stall forever
               err_d   = 1'b1;
               state_d = (state_q == POLL_A) ? WR_A : WR_D;
            end else begin
               poll_cnt_d = poll_cnt_q + PW'(1);
            end
         end
         WR_A: begin
            last_addr_d  = cur_addr_q;
            last_valid_d = 1'b1;
            set_cnt_d    = '0;
            state_d      = SET_A;
         end
         WR_D: begin
            set_cnt_d = '0;
            state_d   = SET_D;
         end
         SET_A, SET_D: begin
            // Busy lags the strobe, so it is not trusted until the settle window ends
            if (set_cnt_q == SW'(SETTLE - 1)) begin
               poll_cnt_d = '0;
               state_d    = (state_q == SET_A) ? POLL_D : IDLE;
            end else begin
               set_cnt_d = set_cnt_q + SW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      cs_n_d = !((state_d == WR_A) || (state_d == WR_D));
      wr_n_d = cs_n_d;
      a0_d   = a0_q;
      din_d  = din_q;
      if (state_d == WR_A) begin
         a0_d  = 1'b0;
         din_d = cur_addr_d;
      end else if (state_d == WR_D) begin
         a0_d  = 1'b1;
         din_d = cur_data_d;
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         state_q      <= IDLE;
         cur_addr_q   <= '0;
         cur_data_q   <= '0;
         poll_cnt_q   <= '0;
         set_cnt_q    <= '0;
         last_addr_q  <= '0;
         last_valid_q <= 1'b0;
         err_q        <= 1'b0;
         cs_n_q       <= 1'b1;
         wr_n_q       <= 1'b1;
         a0_q         <= 1'b0;
         din_q        <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         state_q      <= state_d;
         cur_addr_q   <= cur_addr_d;
         cur_data_q   <= cur_data_d;
         poll_cnt_q   <= poll_cnt_d;
         set_cnt_q    <= set_cnt_d;
         last_addr_q  <= last_addr_d;
         last_valid_q <= last_valid_d;
         err_q        <= err_d;
         cs_n_q       <= cs_n_d;
         wr_n_q       <= wr_n_d;
         a0_q         <= a0_d;
         din_q        <= din_d;
      end
   end

   assign ym_cs_n     = cs_n_q;
   assign ym_wr_n     = wr_n_q;
   assign ym_a0       = a0_q;
   assign ym_din      = din_q;
   assign idle        = (state_q == IDLE) && (level_q == '0);
   assign fifo_level  = level_q;
   assign timeout_err = err_q;

endmodule

// File: tb/tb_jt51_host_wr.sv
// tb/tb_jt51_host_wr.sv - randomized self-checking bench for jt51_host_wr
module tb_jt51_host_wr;

   logic       clk;
   logic       rst_n;
   logic       cmd_valid   [2];
   logic       cmd_ready   [2];
   logic [7:0] cmd_addr    [2];
   logic [7:0] cmd_data    [2];
   logic       ym_cs_n     [2];
   logic       ym_wr_n     [2];
   logic       ym_a0       [2];
   logic [7:0] ym_din      [2];
   logic [7:0] ym_dout     [2];
   logic       idle        [2];
   logic [2:0] fifo_level  [2];
   logic       timeout_err [2];
   logic       err_clr     [2];

   int n_checks = 0;
   int n_fail   = 0;
   int max_level;

   // Strobe records: {dut index, a0, din}
   logic [9:0] obs_q [$];
   logic [9:0] exp_q [$];
   logic       prev_stb [2];
   logic       last_v [2];
   logic [7:0] last_a [2];

   // Instance 0: short timeout, no address skipping
   jt51_host_wr #(.FIFO_AW(2), .SETTLE(2), .TIMEOUT(15), .SKIP_SAME_ADDR(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
      .cmd_addr(cmd_addr[0]), .cmd_data(cmd_data[0]),
      .ym_cs_n(ym_cs_n[0]), .ym_wr_n(ym_wr_n[0]), .ym_a0(ym_a0[0]), .ym_din(ym_din[0]),
      .ym_dout(ym_dout[0]), .idle(idle[0]), .fifo_level(fifo_level[0]),
      .timeout_err(timeout_err[0]), .err_clr(err_clr[0])
   );

   // Instance 1: long timeout, address skipping enabled
   jt51_host_wr #(.FIFO_AW(2), .SETTLE(2), .TIMEOUT(1023), .SKIP_SAME_ADDR(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
      .cmd_addr(cmd_addr[1]), .cmd_data(cmd_data[1]),
      .ym_cs_n(ym_cs_n[1]), .ym_wr_n(ym_wr_n[1]), .ym_a0(ym_a0[1]), .ym_din(ym_din[1]),
      .ym_dout(ym_dout[1]), .idle(idle[1]), .fifo_level(fifo_level[1]),
      .timeout_err(timeout_err[1]), .err_clr(err_clr[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: each command yields an address write (unless skipped) then a data write
   task automatic model_cmd(input int i, input logic [7:0] a, input logic [7:0] d);
      logic b;
      b = (i == 1);
      if (!(i == 1 && last_v[1] && last_a[1] == a)) begin
         exp_q.push_back({b, 1'b0, a});
         last_v[i] = 1'b1;
         last_a[i] = a;
      end
      exp_q.push_back({b, 1'b1, d});
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) last_v[i] = 1'b0;
   endtask

   // Capture every write strobe and confirm it is a single clock wide
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         logic stb;
         logic b;
         stb = !ym_cs_n[i] && !ym_wr_n[i];
         b   = (i == 1);
         if (stb) begin
            check($sformatf("strobe_width%0d", i), prev_stb[i], 0);
            obs_q.push_back({b, ym_a0[i], ym_din[i]});
         end
         prev_stb[i] = stb;
      end
   end

   task automatic push(input int i, input logic [7:0] a, input logic [7:0] d);
      bit done;
      done = 0;
      cmd_valid[i] = 1'b1;
      cmd_addr[i]  = a;
      cmd_data[i]  = d;
      for (int t = 0; t < 300 && !done; t++) begin
         check($sformatf("ready_vs_level%0d", i), cmd_ready[i], fifo_level[i] != 3'd4);
         if (int'(fifo_level[i]) > max_level) max_level = int'(fifo_level[i]);
         if (cmd_ready[i]) begin
            done = 1;
            model_cmd(i, a, d);
         end
         step();
      end
      cmd_valid[i] = 1'b0;
      check($sformatf("push_accept%0d", i), done, 1);
   endtask

   task automatic wait_strobe(input int i, input string tag, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (ym_cs_n[i] && n < 300);
      check(tag, ym_cs_n[i], 0);
   endtask

   task automatic wait_idle(input int i, input string tag);
      int n;
      n = 0;
      while (!idle[i] && n < 1000) begin
         step();
         n++;
      end
      check(tag, idle[i], 1);
   endtask

   task automatic compare_streams(input string tag);
      for (int i = 0; i < 2; i++) begin
         logic [8:0] o[$];
         logic [8:0] e[$];
         foreach (obs_q[k]) if (obs_q[k][9] == (i == 1)) o.push_back(obs_q[k][8:0]);
         foreach (exp_q[k]) if (exp_q[k][9] == (i == 1)) e.push_back(exp_q[k][8:0]);
         check($sformatf("%s_len%0d", tag, i), o.size(), e.size());
         for (int k = 0; k < o.size() && k < e.size(); k++)
            check($sformatf("%s_item%0d_%0d", tag, i, k), o[k], e[k]);
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int n;
      bit acc [2];
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         cmd_valid[i] = 1'b0;
         cmd_addr[i]  = '0;
         cmd_data[i]  = '0;
         ym_dout[i]   = '0;
         err_clr[i]   = 1'b0;
         prev_stb[i]  = 1'b0;
      end
      model_reset();
      step();
      step();
      for (int i = 0; i < 2; i++) begin
         check($sformatf("rst_cs_n%0d", i), ym_cs_n[i], 1);
         check($sformatf("rst_wr_n%0d", i), ym_wr_n[i], 1);
         check($sformatf("rst_a0%0d", i), ym_a0[i], 0);
         check($sformatf("rst_din%0d", i), ym_din[i], 0);
         check($sformatf("rst_level%0d", i), fifo_level[i], 0);
         check($sformatf("rst_ready%0d", i), cmd_ready[i], 1);
         check($sformatf("rst_idle%0d", i), idle[i], 1);
         check($sformatf("rst_err%0d", i), timeout_err[i], 0);
      end
      rst_n = 1'b1;
      step();

      // Single write with busy low: exact strobe cycles and idle timing
      push(0, 8'h08, 8'h7F);
      check("t1_level", fifo_level[0], 1);
      for (int k = 1; k <= 10; k++) begin
         step();
         check($sformatf("t1_cs_n_c%0d", k), ym_cs_n[0], (k == 2 || k == 6) ? 1'b0 : 1'b1);
         check($sformatf("t1_wr_n_c%0d", k), ym_wr_n[0], (k == 2 || k == 6) ? 1'b0 : 1'b1);
         check($sformatf("t1_idle_c%0d", k), idle[0], (k >= 9) ? 1'b1 : 1'b0);
         if (k == 2) begin
            check("t1_a0_addr", ym_a0[0], 0);
            check("t1_din_addr", ym_din[0], 8'h08);
         end
         if (k == 4) check("t1_din_hold", ym_din[0], 8'h08);
         if (k == 6) begin
            check("t1_a0_data", ym_a0[0], 1);
            check("t1_din_data", ym_din[0], 8'h7F);
         end
      end
      compare_streams("t1");

      // Busy held high for 20 cycles after the address strobe
      push(1, 8'h40, 8'h55);
      wait_strobe(1, "t2_addr_seen", n);
      check("t2_addr_lat", n, 2);
      ym_dout[1] = 8'h80;
      for (int k = 0; k < 20; k++) begin
         step();
         check($sformatf("t2_no_strobe%0d", k), ym_cs_n[1], 1);
      end
      ym_dout[1] = 8'h00;
      step();
      check("t2_data_cs", ym_cs_n[1], 0);
      check("t2_data_a0", ym_a0[1], 1);
      check("t2_data_din", ym_din[1], 8'h55);
      check("t2_no_err", timeout_err[1], 0);
      wait_idle(1, "t2_idle");
      compare_streams("t2");

      // Busy stuck high: both phases forced after TIMEOUT poll cycles
      ym_dout[0] = 8'hFF;
      push(0, 8'h10, 8'h22);
      wait_strobe(0, "t3_addr_seen", n);
      check("t3_addr_lat", n, 16);
      check("t3_err_set", timeout_err[0], 1);
      wait_strobe(0, "t3_data_seen", n);
      check("t3_data_lat", n, 18);
      wait_idle(0, "t3_idle");
      ym_dout[0] = 8'h00;
      step();
      check("t3_err_sticky", timeout_err[0], 1);
      err_clr[0] = 1'b1;
      step();
      err_clr[0] = 1'b0;
      check("t3_err_clr", timeout_err[0], 0);
      compare_streams("t3");

      // FIFO fill with busy high: backpressure at full, order preserved
      ym_dout[0] = 8'h80;
      max_level = 0;
      for (int c = 0; c < 6; c++) push(0, 8'(8'h50 + c), 8'($urandom));
      check("t4_level_full", max_level, 4);
      ym_dout[0] = 8'h00;
      wait_idle(0, "t4_idle");
      compare_streams("t4");
      err_clr[0] = 1'b1;
      step();
      err_clr[0] = 1'b0;

      // Address skipping for repeated register addresses
      push(1, 8'h20, 8'h01);
      push(1, 8'h20, 8'h02);
      push(1, 8'h28, 8'h03);
      wait_idle(1, "t5_idle");
      compare_streams("t5");

      // Reset during the address settle window abandons the command
      push(0, 8'h30, 8'h44);
      push(0, 8'h31, 8'h45);
      wait_strobe(0, "t6_addr_seen", n);
      step();
      check("t6_level_pre", fifo_level[0], 1);
      rst_n = 1'b0;
      model_reset();
      #1;
      check("t6_rst_cs_n", ym_cs_n[0], 1);
      check("t6_rst_wr_n", ym_wr_n[0], 1);
      check("t6_rst_level", fifo_level[0], 0);
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) step();
      check("t6_idle", idle[0], 1);
      exp_q.delete();
      exp_q.push_back({1'b0, 1'b0, 8'h30});
      compare_streams("t6");

      // Randomized traffic on both instances with random busy
      for (int c = 0; c < 800; c++) begin
         for (int i = 0; i < 2; i++) begin
            if (!cmd_valid[i] && $urandom_range(0, 2) == 0) begin
               cmd_valid[i] = 1'b1;
               cmd_addr[i]  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 1) * 8 + 8'h20)
                                                          : 8'($urandom);
               cmd_data[i]  = 8'($urandom);
            end
            ym_dout[i] = {($urandom_range(0, 3) == 0), 7'($urandom)};
            acc[i] = cmd_valid[i] && cmd_ready[i];
         end
         step();
         for (int i = 0; i < 2; i++) begin
            if (acc[i]) begin
               model_cmd(i, cmd_addr[i], cmd_data[i]);
               cmd_valid[i] = 1'b0;
            end
         end
      end
      for (int i = 0; i < 2; i++) begin
         cmd_valid[i] = 1'b0;
         ym_dout[i]   = 8'h00;
      end
      wait_idle(0, "t7_idle0");
      wait_idle(1, "t7_idle1");
      step();
      compare_streams("t7");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
